// File: rtl/lcd_bus_arbiter.sv
// Two-port round-robin arbiter for a shared HD44780 write-only bus; each granted byte
// is driven through setup, EN pulse, hold and execution wait before the requester is acked.
//   state | meaning
//   PWRUP | controller power-up delay, requests ignored
//   IDLE  | arbitrate between eligible ports
//   SETUP | RS/DATA settling before EN rises
//   EN_HI | EN strobe high
//   HOLD  | RS/DATA held after EN falls
//   EXEC  | waiting for the LCD to execute the byte
module lcd_bus_arbiter #(
  parameter int T_PWRUP     = 750000,
  parameter int T_SETUP     = 4,
  parameter int T_EN_HIGH   = 25,
  parameter int T_HOLD      = 4,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000,
  parameter int CW          = 20
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en
);

  localparam longint CNT_MAX = (longint'(1) << CW) - 1;

  if (longint'(T_PWRUP) > CNT_MAX || longint'(T_SETUP) > CNT_MAX ||
      longint'(T_EN_HIGH) > CNT_MAX || longint'(T_HOLD) > CNT_MAX ||
      longint'(T_EXEC) > CNT_MAX || longint'(T_EXEC_LONG) > CNT_MAX ||
      T_PWRUP < 1 || T_EN_HIGH < 1 || T_HOLD < 1 || T_EXEC < 1 || T_EXEC_LONG < 1) begin : g_cw_check
    $error("lcd_bus_arbiter: CW too narrow or a timing parameter is zero");
  end

  typedef enum logic [2:0] {PWRUP, IDLE, SETUP, EN_HI, HOLD, EXEC} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] exec_tc;
  logic          last_grant, grant_nx;
  logic [7:0]    data_nx;
  logic          rs_nx, en_nx, ack0_nx, ack1_nx;
  logic          elig0, elig1, long_cmd;

  // a request coinciding with its own ack is the tail of the transfer just finished
  assign elig0    = req0 & ~ack0;
  assign elig1    = req1 & ~ack1;
  assign long_cmd = ~lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);
  assign exec_tc  = long_cmd ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    grant_nx = last_grant;
    data_nx  = lcd_data;
    rs_nx    = lcd_rs;
    en_nx    = lcd_en;
    ack0_nx  = 1'b0;
    ack1_nx  = 1'b0;
    case (state)
      PWRUP: begin
        if (cnt == CW'(T_PWRUP - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      IDLE: begin
        cnt_nx = '0;
        if (elig0 && (!elig1 || last_grant)) begin
          state_nx = SETUP;
          grant_nx = 1'b0;
          data_nx  = data0;
          rs_nx    = rs0;
        end else if (elig1) begin
          state_nx = SETUP;
          grant_nx = 1'b1;
          data_nx  = data1;
          rs_nx    = rs1;
        end
      end
      // SETUP runs one extra cycle so EN rises T_SETUP+1 edges after the grant
      SETUP: begin
        if (cnt == CW'(T_SETUP)) begin
          state_nx = EN_HI;
          cnt_nx   = '0;
          en_nx    = 1'b1;
        end
      end
      EN_HI: begin
        if (cnt == CW'(T_EN_HIGH - 1)) begin
          state_nx = HOLD;
          cnt_nx   = '0;
          en_nx    = 1'b0;
        end
      end
      HOLD: begin
        if (cnt == CW'(T_HOLD - 1)) begin
          state_nx = EXEC;
          cnt_nx   = '0;
        end
      end
      EXEC: begin
        if (cnt == exec_tc) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          ack0_nx  = ~last_grant;
          ack1_nx  = last_grant;
        end
      end
      default: begin
        state_nx = PWRUP;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= PWRUP;
      cnt        <= '0;
      last_grant <= 1'b1;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_en     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last_grant <= grant_nx;
      lcd_data   <= data_nx;
      lcd_rs     <= rs_nx;
      lcd_rw     <= 1'b0;
      lcd_en     <= en_nx;
      ack0       <= ack0_nx;
      ack1       <= ack1_nx;
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed transfers with a scoreboard of expected bytes,
// popped and timed by a bus monitor as each transfer completes.
module tb_lcd_bus_arbiter;

  localparam int P_PWRUP     = 10;
  localparam int P_SETUP     = 4;
  localparam int P_EN_HIGH   = 25;
  localparam int P_HOLD      = 4;
  localparam int P_EXEC      = 20;
  localparam int P_EXEC_LONG = 100;

  logic       CLOCK_50;
  logic       rst;
  logic       req0, rs0, req1, rs1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, busy;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en;

  lcd_bus_arbiter #(
    .T_PWRUP(P_PWRUP), .T_SETUP(P_SETUP), .T_EN_HIGH(P_EN_HIGH), .T_HOLD(P_HOLD),
    .T_EXEC(P_EXEC), .T_EXEC_LONG(P_EXEC_LONG), .CW(20)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .busy(busy), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  typedef struct {
    bit         port;
    bit         rs;
    logic [7:0] data;
    int         exec;
  } xfer_t;

  xfer_t sb[$];
  xfer_t cur;
  int    n_asserts = 0;
  int    n_fail    = 0;
  int    acks_seen = 0;
  int    cyc       = 0;
  int    g_cyc     = 0;
  int    en_len    = 0;
  bit    active    = 0;
  bit    unstable  = 0;
  logic  prev_busy = 1'b1;
  logic  prev_en   = 1'b0;

  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input bit port, input bit rs, input logic [7:0] d);
    xfer_t x;
    x.port = port;
    x.rs   = rs;
    x.data = d;
    x.exec = (!rs && d[7:2] == 6'd0 && d[1:0] != 2'd0) ? P_EXEC_LONG : P_EXEC;
    sb.push_back(x);
  endfunction

  task automatic wait_ack(input bit port);
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge CLOCK_50);
      got = port ? ack1 : ack0;
    end
    check(port ? "ack1_wait" : "ack0_wait", got, 1);
  endtask

  task automatic do_xfer(input bit port, input bit rs, input logic [7:0] d);
    push(port, rs, d);
    if (port) begin rs1 = rs; data1 = d; req1 = 1'b1; end
    else      begin rs0 = rs; data0 = d; req0 = 1'b1; end
    wait_ack(port);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  // bus monitor: grant = busy rising out of IDLE; times EN and ack against the model
  always @(posedge CLOCK_50) begin
    #1;
    cyc++;
    if (rst) begin
      active = 0;
      en_len = 0;
    end else begin
      if (busy && !prev_busy) begin
        check("grant_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          cur      = sb[0];
          active   = 1;
          g_cyc    = cyc;
          en_len   = 0;
          unstable = 0;
          check("grant_data", lcd_data, cur.data);
          check("grant_rs", lcd_rs, cur.rs);
          check("grant_rw", lcd_rw, 0);
        end
      end
      if (active && (lcd_data !== cur.data || lcd_rs !== cur.rs)) unstable = 1;
      if (lcd_en && !prev_en) begin
        check("en_rise_active", active, 1);
        if (active) check("en_rise_ofs", cyc - g_cyc, P_SETUP + 1);
      end
      if (!lcd_en && prev_en) check("en_high_len", en_len, P_EN_HIGH);
      if (lcd_en) en_len++;
      if (ack0 || ack1) begin
        check("ack_one_port", ack0 && ack1, 0);
        check("ack_active", active, 1);
        if (active) begin
          check("ack_port", ack1, cur.port);
          check("ack_ofs", cyc - g_cyc, P_SETUP + P_EN_HIGH + P_HOLD + cur.exec + 1);
          check("ack_busy", busy, 0);
          check("data_stable", unstable, 0);
          void'(sb.pop_front());
          active = 0;
          acks_seen++;
        end
      end
    end
    prev_busy = busy;
    prev_en   = lcd_en;
  end

  initial begin
    int  base;
    bit  got;
    rst = 1'b1;
    req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
    req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
    repeat (3) @(negedge CLOCK_50);

    check("rst_lcd_data", lcd_data, 8'h00);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_en", lcd_en, 0);
    check("rst_lcd_rw", lcd_rw, 0);
    check("rst_acks", {ack0, ack1}, 2'b00);
    check("rst_busy", busy, 1);

    // power-up hold-off with port 0 requesting from the first cycle
    push(0, 0, 8'h38);
    rs0 = 1'b0; data0 = 8'h38; req0 = 1'b1; rst = 1'b0;
    for (int i = 0; i < P_PWRUP - 1; i++) begin
      @(negedge CLOCK_50);
      check("pwrup_busy", busy, 1);
      check("pwrup_en", lcd_en, 0);
    end
    @(negedge CLOCK_50);
    check("pwrup_first_idle", busy, 0);
    @(negedge CLOCK_50);
    check("pwrup_grant", busy, 1);
    check("pwrup_grant_data", {lcd_rs, lcd_data}, 9'h038);
    req0 = 1'b0;  // dropped after grant: transfer must still complete
    wait_ack(0);

    // execution-wait selection
    do_xfer(0, 0, 8'h01);
    do_xfer(0, 1, 8'h01);
    do_xfer(0, 0, 8'h04);
    do_xfer(0, 0, 8'h02);
    do_xfer(1, 0, 8'h03);

    // contention: last grant was port 1, so port 0 goes first
    push(0, 0, 8'hA0); push(1, 0, 8'hB1); push(0, 0, 8'hA0); push(1, 0, 8'hB1);
    rs0 = 1'b0; data0 = 8'hA0; rs1 = 1'b0; data1 = 8'hB1;
    req0 = 1'b1; req1 = 1'b1;
    base = acks_seen;
    for (int i = 0; i < 1000 && acks_seen < base + 4; i++) @(negedge CLOCK_50);
    check("contention_acks", acks_seen - base, 4);
    req0 = 1'b0; req1 = 1'b0;
    check("contention_sb_empty", sb.size(), 0);

    // single requester streaming on port 1
    push(1, 0, 8'h41); push(1, 0, 8'h42); push(1, 0, 8'h43);
    rs1 = 1'b0; data1 = 8'h41; req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ack(1);
      if (i < 2) begin
        data1 = 8'(8'h42 + i);
        @(negedge CLOCK_50);
        check("stream_idle_gap", busy, 0);
        @(negedge CLOCK_50);
        check("stream_regrant", busy, 1);
      end
    end
    req1 = 1'b0;

    // reset during EN high: pending transfer is dropped, power-up restarts
    push(0, 1, 8'h55);
    rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge CLOCK_50);
      got = lcd_en;
    end
    check("en_hi_reached", got, 1);
    repeat (3) @(negedge CLOCK_50);
    rst = 1'b1; req0 = 1'b0;
    @(negedge CLOCK_50);
    check("midrst_en", lcd_en, 0);
    check("midrst_acks", {ack0, ack1}, 2'b00);
    check("midrst_busy", busy, 1);
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < P_PWRUP - 1; i++) begin
      @(negedge CLOCK_50);
      check("repwrup_busy", busy, 1);
    end
    @(negedge CLOCK_50);
    check("repwrup_idle", busy, 0);

    do_xfer(1, 1, 8'h80);
    repeat (5) @(negedge CLOCK_50);
    check("final_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
